capture_readout: RTL
====================

Name: capture_readout

Overview:
- Controller directly downstream of the circular sample-buffer writer in the internal logic analyzer.
- Gates the writer's write_enable, detects the trigger, and lets POST_TRIG_DEPTH further samples land in the buffer before freezing it.
- Then streams the frozen buffer out oldest-first over a valid/ready interface to the host-side link.

Parameters:
- DATA_WIDTH, 8, sample width.
- ADDR_WIDTH, 4, buffer address width.
- MEMORY_SIZE, 16, buffer depth; must equal 2**ADDR_WIDTH.
- POST_TRIG_DEPTH, 8, samples written after the trigger cycle; range 0..MEMORY_SIZE-1.

Ports:
- clk  in  1  sampling/system clock.
- reset  in  1  asynchronous, active-high reset.
- trigger  in  1  trigger condition, sampled in ARMED only.
- rearm  in  1  return from DONE to ARMED.
- waddr  in  ADDR_WIDTH  writer's next write address.
- primed  in  1  writer has wrapped at least once.
- write_enable  out  1  drives the writer's write_enable.
- wr_reset  out  1  one-cycle pulse to the writer's synchronous reset.
- raddr  out  ADDR_WIDTH  buffer read address.
- rdata  in  DATA_WIDTH  buffer read data, valid 1 cycle after raddr.
- o_data  out  DATA_WIDTH  output sample.
- o_valid  out  1  o_data valid.
- o_ready  in  1  consumer accepts when o_valid && o_ready.
- o_last  out  1  marks the final word of a dump.
- done  out  1  high in DONE.

Behaviour:
- Reset: all outputs 0 (write_enable, wr_reset, raddr, o_data, o_valid, o_last, done). State ARMED. Internal counters 0.
- FSM states: ARMED, POST, FETCH, WAIT, SEND, DONE.
- ARMED:
  - write_enable=1.
  - trigger=1 goes to POST, with post counter loaded to POST_TRIG_DEPTH.
  - If POST_TRIG_DEPTH=0, trigger goes straight to FETCH and write_enable drops the next cycle. The trigger-cycle sample is still written.
- POST:
  - write_enable=1; the counter decrements each cycle.
  - Leave for FETCH in the cycle the counter reaches 1, so that exactly POST_TRIG_DEPTH samples follow the trigger sample.
  - write_enable is registered low on entry to FETCH. trigger is ignored.
- Readout start (entry to FETCH):
  - Start address = primed ? waddr : 0.
  - Word count = primed ? MEMORY_SIZE : waddr, held in an (ADDR_WIDTH+1)-bit counter.
  - If the count is 0, go directly to DONE with no output.
- FETCH: drive raddr, then go to WAIT.
- WAIT: capture rdata into o_data, set o_valid=1, go to SEND.
- SEND:
  - Hold o_data/o_valid stable while o_ready=0.
  - On accept: o_valid=0, raddr+1 (wraps modulo MEMORY_SIZE), count-1.
  - Next state is FETCH, or DONE if this was the last word.
  - o_last=1 exactly while the final word is valid.
- Throughput: one word per 3 cycles minimum. Latency from o_valid asserting to data is 0.
- DONE:
  - done=1, write_enable=0.
  - rearm=1 gives a one-cycle wr_reset pulse and a return to ARMED. The writer's waddr and primed clear on that edge; write_enable reasserts the next cycle.
  - rearm is ignored in every other state.
- Reset mid-readout aborts immediately: o_valid drops asynchronously. A partial dump is not resumed.
- trigger and rearm asserted together in DONE: rearm wins, and trigger is not latched.

Optional Feature:
- Macro: ILA_READOUT_HEADER_EN.
- When defined: before the first sample, one header word equal to the word count (zero-extended or truncated to DATA_WIDTH) is sent on the same handshake.
  - The dump is count+1 words; o_last stays on the final sample.
  - With a count of 0, the header alone is sent, with o_last=1.
- When undefined: no header; behaviour is exactly as above.

Decomposition:
- define.v holds DATA_WIDTH, ADDR_WIDTH, MEMORY_SIZE, POST_TRIG_DEPTH defaults and the state encodings (localparams, one-hot or binary, 3 bits).
- One sub-module, rd_addr_gen: loads start address and count, increments and wraps raddr, and flags the last word.

Test Plan:
- Unprimed dump:
  - Stimulus: reset; write_enable stays high; trigger at waddr=2; POST_TRIG_DEPTH=8; o_ready=1.
  - Required: 11 words read from addresses 0..10, oldest first; write_enable low after 8 post-trigger writes; o_last on the 11th word; done=1.
- Primed wrap:
  - Stimulus: run 40 cycles, then trigger.
  - Required: 16 words starting at the frozen waddr and wrapping 15 to 0.
- Backpressure:
  - Stimulus: o_ready toggles 0/1 every 2 cycles.
  - Required: o_data stable while o_valid && !o_ready; no word lost or duplicated.
- Rearm:
  - Stimulus: assert rearm in DONE.
  - Required: wr_reset pulses once; ARMED; trigger together with rearm is not latched; a second capture is correct.
- Mid-readout reset:
  - Stimulus: assert reset during SEND.
  - Required: o_valid=0 at once; ARMED with write_enable=1 after release.
- Header build (ILA_READOUT_HEADER_EN):
  - Required: the primed dump's first word is 16 truncated to 8 bits, i.e. 0x10, followed by 16 samples.

Source files
------------

// File: rtl/capture_readout_pkg.sv
// capture_readout_pkg
//   Shared defaults and FSM state encoding for the logic-analyzer capture
//   controller (capture_readout) and its read-address generator (rd_addr_gen).
//   Optional feature macro used by capture_readout: ILA_READOUT_HEADER_EN.
package capture_readout_pkg;

   localparam int DEF_DATA_WIDTH      = 8;
   localparam int DEF_ADDR_WIDTH      = 4;
   localparam int DEF_MEMORY_SIZE     = 16;
   localparam int DEF_POST_TRIG_DEPTH = 8;

   typedef enum logic [2:0] {
      ST_ARMED = 3'd0,
      ST_POST  = 3'd1,
      ST_FETCH = 3'd2,
      ST_WAIT  = 3'd3,
      ST_SEND  = 3'd4,
      ST_DONE  = 3'd5
   } state_e;

   // The writer is enabled only while the buffer is still collecting samples.
   function automatic logic is_capture_state(input state_e s);
      return (s == ST_ARMED) || (s == ST_POST);
   endfunction

endpackage

// File: rtl/capture_readout_rd_addr_gen.sv
// rd_addr_gen
//   Readout address/count generator. Loads a start address and word count,
//   advances the read address (wrapping modulo 2**ADDR_WIDTH) and decrements
//   the remaining count once per accepted word, and flags the last word.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   load_i            load start_addr_i / count_i (has priority over advance)
//   start_addr_i      first read address of the dump
//   count_i           number of words in the dump (ADDR_WIDTH+1 bits)
//   advance_i         one word accepted: step address, decrement count
//   raddr_o           current read address
//   count_o           words still to be sent, including the current one
//   last_o            current word is the final one
module rd_addr_gen
   import capture_readout_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load_i,
   input  logic [ADDR_WIDTH-1:0] start_addr_i,
   input  logic [ADDR_WIDTH:0]   count_i,
   input  logic                  advance_i,
   output logic [ADDR_WIDTH-1:0] raddr_o,
   output logic [ADDR_WIDTH:0]   count_o,
   output logic                  last_o
);

   localparam int CNT_W = ADDR_WIDTH + 1;

   logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
   logic [CNT_W-1:0]      count_q, count_d;

   always_comb begin
      raddr_d = raddr_q;
      count_d = count_q;
      if (load_i) begin
         raddr_d = start_addr_i;
         count_d = count_i;
      end else if (advance_i) begin
         // Buffer depth is a power of two, so natural overflow is the wrap.
         raddr_d = raddr_q + ADDR_WIDTH'(1);
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         raddr_q <= '0;
         count_q <= '0;
      end else begin
         raddr_q <= raddr_d;
         count_q <= count_d;
      end
   end

   assign raddr_o = raddr_q;
   assign count_o = count_q;
   assign last_o  = (count_q == CNT_W'(1));

endmodule

// File: rtl/capture_readout.sv
// capture_readout
//   Capture controller for the internal logic analyzer. Gates the circular
//   buffer writer, waits POST_TRIG_DEPTH samples after the trigger, freezes
//   the buffer and streams it out oldest-first on a valid/ready interface.
//   Optional macro ILA_READOUT_HEADER_EN: prefix each dump with a header word
//   holding the word count.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   trigger           trigger condition (honoured in ARMED only)
//   rearm             DONE -> ARMED, pulses wr_reset
//   waddr, primed     writer's next write address / has-wrapped flag
//   write_enable      writer enable
//   wr_reset          one-cycle synchronous reset to the writer
//   raddr, rdata      buffer read port (rdata one cycle after raddr)
//   o_data/o_valid/o_ready/o_last   output stream
//   done              dump finished
module capture_readout
   import capture_readout_pkg::*;
#(
   parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
   parameter int MEMORY_SIZE     = DEF_MEMORY_SIZE,
   parameter int POST_TRIG_DEPTH = DEF_POST_TRIG_DEPTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  trigger,
   input  logic                  rearm,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic                  primed,
   output logic                  write_enable,
   output logic                  wr_reset,
   output logic [ADDR_WIDTH-1:0] raddr,
   input  logic [DATA_WIDTH-1:0] rdata,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  o_valid,
   input  logic                  o_ready,
   output logic                  o_last,
   output logic                  done
);

   localparam int CNT_W = ADDR_WIDTH + 1;

`ifdef ILA_READOUT_HEADER_EN
   localparam bit HDR_EN = 1'b1;
`else
   localparam bit HDR_EN = 1'b0;
`endif

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] post_cnt_q, post_cnt_d;
   logic                  hdr_q, hdr_d;
   logic [DATA_WIDTH-1:0] o_data_q, o_data_d;
   logic                  o_valid_q, o_valid_d;
   logic                  o_last_q, o_last_d;
   logic                  write_enable_q;
   logic                  done_q;

   logic                  start_rd;
   logic                  rd_load;
   logic                  rd_advance;
   logic [ADDR_WIDTH-1:0] rd_raddr;
   logic [CNT_W-1:0]      rd_count;
   logic                  rd_last;

   // The writer commits its final sample on the same edge that freezes the
   // buffer, so the readout window is taken from its post-write address and
   // wrap status rather than the values it presents during that cycle.
   logic [ADDR_WIDTH-1:0] eff_waddr;
   logic                  eff_primed;
   logic [ADDR_WIDTH-1:0] start_addr;
   logic [CNT_W-1:0]      start_count;

   assign eff_waddr   = write_enable_q ? (waddr + ADDR_WIDTH'(1)) : waddr;
   assign eff_primed  = primed | (write_enable_q & (&waddr));
   assign start_addr  = eff_primed ? eff_waddr : '0;
   assign start_count = eff_primed ? CNT_W'(MEMORY_SIZE) : {1'b0, eff_waddr};

   // Header word: word count zero-extended or truncated to DATA_WIDTH.
   logic [DATA_WIDTH-1:0] hdr_word;
   if (DATA_WIDTH > CNT_W) begin : g_hdr_pad
      assign hdr_word = {{(DATA_WIDTH-CNT_W){1'b0}}, rd_count};
   end else begin : g_hdr_trunc
      assign hdr_word = rd_count[DATA_WIDTH-1:0];
   end

   rd_addr_gen #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_rd_addr_gen (
      .clk          (clk),
      .rst          (reset),
      .load_i       (rd_load),
      .start_addr_i (start_addr),
      .count_i      (start_count),
      .advance_i    (rd_advance),
      .raddr_o      (rd_raddr),
      .count_o      (rd_count),
      .last_o       (rd_last)
   );

   always_comb begin
      state_d    = state_q;
      post_cnt_d = post_cnt_q;
      hdr_d      = hdr_q;
      o_data_d   = o_data_q;
      o_valid_d  = o_valid_q;
      o_last_d   = o_last_q;
      start_rd   = 1'b0;
      rd_load    = 1'b0;
      rd_advance = 1'b0;

      unique case (state_q)
         ST_ARMED: begin
            if (trigger) begin
               if (POST_TRIG_DEPTH == 0) begin
                  start_rd = 1'b1;
               end else begin
                  post_cnt_d = ADDR_WIDTH'(POST_TRIG_DEPTH);
                  state_d    = ST_POST;
               end
            end
         end
         ST_POST: begin
            // Leaving while the counter reads 1 lets exactly POST_TRIG_DEPTH
            // samples follow the trigger sample.
            if (post_cnt_q <= ADDR_WIDTH'(1)) begin
               start_rd = 1'b1;
            end else begin
               post_cnt_d = post_cnt_q - ADDR_WIDTH'(1);
            end
         end
         ST_FETCH: begin
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            o_valid_d = 1'b1;
            if (hdr_q) begin
               o_data_d = hdr_word;
               o_last_d = (rd_count == '0);
            end else begin
               o_data_d = rdata;
               o_last_d = rd_last;
            end
            state_d = ST_SEND;
         end
         ST_SEND: begin
            if (o_ready) begin
               o_valid_d = 1'b0;
               o_last_d  = 1'b0;
               if (hdr_q) begin
                  hdr_d   = 1'b0;
                  state_d = (rd_count == '0) ? ST_DONE : ST_FETCH;
               end else begin
                  rd_advance = 1'b1;
                  state_d    = rd_last ? ST_DONE : ST_FETCH;
               end
            end
         end
         ST_DONE: begin
            if (rearm) begin
               state_d = ST_ARMED;
            end
         end
         default: begin
            state_d = ST_ARMED;
         end
      endcase

      if (start_rd) begin
         rd_load = 1'b1;
         if (HDR_EN) begin
            // Header needs no buffer read, so go straight to presenting it.
            hdr_d   = 1'b1;
            state_d = ST_WAIT;
         end else begin
            state_d = (start_count == '0) ? ST_DONE : ST_FETCH;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= ST_ARMED;
         post_cnt_q     <= '0;
         hdr_q          <= 1'b0;
         o_data_q       <= '0;
         o_valid_q      <= 1'b0;
         o_last_q       <= 1'b0;
         write_enable_q <= 1'b0;
         done_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         post_cnt_q     <= post_cnt_d;
         hdr_q          <= hdr_d;
         o_data_q       <= o_data_d;
         o_valid_q      <= o_valid_d;
         o_last_q       <= o_last_d;
         write_enable_q <= is_capture_state(state_d);
         done_q         <= (state_d == ST_DONE);
      end
   end

   // Combinational so the writer clears on the same edge that rearms.
   assign wr_reset     = (state_q == ST_DONE) && rearm;
   assign write_enable = write_enable_q;
   assign raddr        = rd_raddr;
   assign o_data       = o_data_q;
   assign o_valid      = o_valid_q;
   assign o_last       = o_last_q;
   assign done         = done_q;

endmodule
